spi_tx: RTL

- SPI master transmitter: the sending end of the SPI trigger path.
- Serializes one 8- or 16-bit word onto SS_n/SCLK/MOSI using the same edge and length conventions as the SPI trigger receiver.
- Used as the on-chip stimulus source for protocol-trigger self-test and for configuring external front-end parts (threshold DACs).
- Driven by the command/config logic through a single-cycle wrt strobe with busy/done status.

---
 rtl/spi_tx_if.sv | 34 +++
 rtl/spi_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spi_tx_if.sv
//============================================================================
// Module      : spi_tx_if
// Description : Command-side handshake and SPI pin bundle for spi_tx.
//               master = command/config logic, slave = the transmitter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

interface spi_tx_if;
    logic        wrt;
    logic [15:0] tx_data;
    logic        len8_16;
    logic        edg;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        busy;
    logic        done;

    // Command logic: issues frames, observes status and the serial lines
    modport master (
        output wrt, tx_data, len8_16, edg,
        input  SS_n, SCLK, MOSI, busy, done
    );

    // Transmitter: accepts frames, drives status and the serial lines
    modport slave (
        input  wrt, tx_data, len8_16, edg,
        output SS_n, SCLK, MOSI, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/spi_tx.sv
//============================================================================
// Module      : spi_tx
// Description : SPI master transmitter. Serializes one 8- or 16-bit word,
//               MSB first, onto SS_n/SCLK/MOSI. SCLK idles high; every bit
//               period starts with a falling edge and ends high. MOSI changes
//               on the edge the receiver does not sample.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_tx #(
    parameter int SCLK_DIV = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_tx_if.slave  bus
);

    localparam int c_DIV_W = $clog2(SCLK_DIV);
    localparam int c_HALF  = SCLK_DIV / 2;

    localparam logic [c_DIV_W-1:0] c_HALF_V  = c_DIV_W'(c_HALF);
    localparam logic [c_DIV_W-1:0] c_HALF_M1 = c_DIV_W'(c_HALF - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_M1  = c_DIV_W'(SCLK_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FRONT = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_BACK  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic [4:0]         r_bit_cnt;
    logic [4:0]         w_bit_nxt;
    logic [15:0]        r_shift;
    logic [15:0]        w_shift_nxt;
    logic               r_len8;
    logic               w_len8_nxt;
    logic               r_edg;
    logic               w_edg_nxt;
    logic               r_ss_n;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_busy;
    logic               r_done;
    logic               w_ss_n_nxt;
    logic               w_sclk_nxt;
    logic               w_mosi_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_last_bit;

    // r_bit_cnt counts completed bit periods; the last one is N-1
    assign w_last_bit = (r_bit_cnt == (r_len8 ? 5'd7 : 5'd15));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: each phase ends on its divider terminal count
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.wrt) w_state_nxt = c_FRONT;
            c_FRONT: if (r_div == c_HALF_M1) w_state_nxt = c_SHIFT;
            c_SHIFT: if ((r_div == c_DIV_M1) && w_last_bit) w_state_nxt = c_BACK;
            c_BACK:  if (r_div == c_HALF_M1) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs
    always_comb begin
        w_div_nxt   = '0;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_len8_nxt  = r_len8;
        w_edg_nxt   = r_edg;

        case (r_state)
            c_IDLE: begin
                w_bit_nxt = 5'd0;
                if (bus.wrt) begin
                    w_len8_nxt  = bus.len8_16;
                    w_edg_nxt   = bus.edg;
                    w_shift_nxt = bus.len8_16 ? {bus.tx_data[7:0], 8'h00} : bus.tx_data;
                end
            end
            c_FRONT, c_BACK: begin
                w_div_nxt = (r_div == c_HALF_M1) ? '0 : r_div + 1'b1;
            end
            c_SHIFT: begin
                if (r_div == c_DIV_M1) begin
                    w_div_nxt = '0;
                    w_bit_nxt = r_bit_cnt + 5'd1;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: w_div_nxt = '0;
        endcase

        // Shift decisions look at the upcoming divider value so that MOSI
        // moves in the same cycle as the non-sampling SCLK edge. With edg=1
        // the first bit is already on MOSI, so bit 1's falling edge is skipped.
        if (w_state_nxt == c_SHIFT) begin
            if (r_edg) begin
                if ((w_div_nxt == '0) && (w_bit_nxt != 5'd0)) begin
                    w_shift_nxt = {r_shift[14:0], 1'b0};
                end
            end else begin
                if (w_div_nxt == c_HALF_V) begin
                    w_shift_nxt = {r_shift[14:0], 1'b0};
                end
            end
        end

        w_ss_n_nxt = (w_state_nxt == c_IDLE);
        w_busy_nxt = (w_state_nxt != c_IDLE);
        w_done_nxt = (r_state == c_BACK) && (w_state_nxt == c_IDLE);
        w_sclk_nxt = !((w_state_nxt == c_SHIFT) && (w_div_nxt < c_HALF_V));
        w_mosi_nxt = w_ss_n_nxt ? 1'b0 : w_shift_nxt[15];
    end

    // Datapath and output registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_bit_cnt <= 5'd0;
            r_shift   <= 16'h0000;
            r_len8    <= 1'b0;
            r_edg     <= 1'b0;
            r_ss_n    <= 1'b1;
            r_sclk    <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_div     <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_len8    <= w_len8_nxt;
            r_edg     <= w_edg_nxt;
            r_ss_n    <= w_ss_n_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.SS_n = r_ss_n;
    assign bus.SCLK = r_sclk;
    assign bus.MOSI = r_mosi;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

`default_nettype wire
